slc3_mem_responder: RTL and testbench

//  Memory-side responder for the SLC3 CPU memory port. It services the read/write requests the

---
 rtl/slc3_mem_responder_pkg.sv | 32 +++
 rtl/slc3_mem_responder_if.sv | 34 +++
 rtl/slc3_mem_responder_sram.sv | 23 ++
 rtl/slc3_mem_responder.sv | 111 +++++++++++
 tb/tb_slc3_mem_responder.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/slc3_mem_responder_pkg.sv
// Shared types for the SLC3 memory responder.
// Holds FSM states, the word type and the address decoder.
package slc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  typedef enum logic [1:0] {
    DEC_RAM,
    DEC_IO,
    DEC_ERR
  } dec_t;

  typedef logic [15:0] word_t;

  localparam word_t IO_ADDR_DEF = 16'hFFFF;

  // I/O wins if it overlaps RAM; RAM needs all upper bits clear.
  function automatic dec_t decode(
    input word_t a,
    input word_t io,
    input int    ab
  );
    if (a == io) return DEC_IO;
    if ((a >> ab) == 16'h0000) return DEC_RAM;
    return DEC_ERR;
  endfunction

endpackage

// File: rtl/slc3_mem_responder_if.sv
// CPU memory port bundle between the SLC3 datapath and its memory.
// The CPU is the master; the responder is the slave.
interface slc3_mem_responder_if;
  import slc3_mem_pkg::*;

  logic  mem_req;
  logic  mem_we;
  word_t mem_addr;
  word_t mem_wdata;
  word_t mem_rdata;
  logic  mem_resp;
  logic  addr_err;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_resp,
    input  addr_err
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_resp,
    output addr_err
  );

endinterface

// File: rtl/slc3_mem_responder_sram.sv
// Single-port program/data RAM with registered read port.
// No reset so that it maps onto block RAM.
module slc3_sram
  import slc3_mem_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  word_t                wdata,
  output word_t                rdata
);

  word_t mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/slc3_mem_responder.sv
// SLC3 memory responder: RAM, wait states and one I/O word
// (switches in, hex display out) behind the CPU memory port.
module slc3_mem_responder
  import slc3_mem_pkg::*;
#(
  parameter int    ADDR_BITS   = 10,
  parameter int    WAIT_STATES = 2,
  parameter word_t IO_ADDR     = IO_ADDR_DEF
) (
  input  logic clk,
  input  logic reset,
  slc3_mem_responder_if.slave bus,
  input  word_t switches,
  output word_t hex_out
);

  localparam logic [3:0] CNT_INIT =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  mem_state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       we_q;
  word_t      addr_q, wdata_q;
  logic       err_q, rd_ram;
  word_t      rd_q, ram_dout;

  logic  in_idle, accept, done;
  logic  cur_we;
  word_t cur_addr, cur_wdata;
  dec_t  cur_dec;

  // With zero wait states the accepting edge also completes,
  // so the live bus is used in IDLE and the captured copy after.
  assign in_idle   = (state == IDLE);
  assign accept    = in_idle && bus.mem_req;
  assign done      = (accept && WAIT_STATES == 0) ||
                     (state == WAIT && cnt == 4'd0);
  assign cur_addr  = in_idle ? bus.mem_addr  : addr_q;
  assign cur_we    = in_idle ? bus.mem_we    : we_q;
  assign cur_wdata = in_idle ? bus.mem_wdata : wdata_q;
  assign cur_dec   = decode(cur_addr, IO_ADDR, ADDR_BITS);

  slc3_sram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_sram (
    .clk  (clk),
    .we   (done && cur_we && cur_dec == DEC_RAM),
    .re   (done && !cur_we && cur_dec == DEC_RAM),
    .addr (cur_addr[ADDR_BITS-1:0]),
    .wdata(cur_wdata),
    .rdata(ram_dout)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.mem_req) begin
          if (WAIT_STATES == 0) begin
            state_n = RESP;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_n = RESP;
        else cnt_n = cnt - 4'd1;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rd_ram  <= 1'b0;
      rd_q    <= '0;
      hex_out <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      err_q <= done && cur_dec == DEC_ERR;
      if (accept) begin
        we_q    <= bus.mem_we;
        addr_q  <= bus.mem_addr;
        wdata_q <= bus.mem_wdata;
      end
      if (done && cur_we && cur_dec == DEC_IO)
        hex_out <= cur_wdata;
      // Read result lives in the RAM port or in rd_q; rd_ram picks.
      if (done && !cur_we) begin
        rd_ram <= (cur_dec == DEC_RAM);
        rd_q   <= (cur_dec == DEC_IO) ? switches : '0;
      end
    end
  end

  assign bus.mem_resp  = (state == RESP);
  assign bus.addr_err  = err_q;
  assign bus.mem_rdata = rd_ram ? ram_dout : rd_q;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Bench for slc3_mem_responder: one instance with 2 wait states,
// one with none, checked against a behavioural memory model.
module tb_slc3_mem_responder;
  import slc3_mem_pkg::*;

  logic  clk = 1'b0;
  logic  reset;
  word_t switches;
  word_t hex_a, hex_b;

  always #5 clk = ~clk;

  logic  req   [2];
  logic  we    [2];
  word_t addr  [2];
  word_t wdata [2];
  word_t rdata [2];
  logic  resp  [2];
  logic  err   [2];
  word_t hex   [2];

  slc3_mem_responder_if bus_a ();
  slc3_mem_responder_if bus_b ();

  assign bus_a.mem_req   = req[0];
  assign bus_a.mem_we    = we[0];
  assign bus_a.mem_addr  = addr[0];
  assign bus_a.mem_wdata = wdata[0];
  assign bus_b.mem_req   = req[1];
  assign bus_b.mem_we    = we[1];
  assign bus_b.mem_addr  = addr[1];
  assign bus_b.mem_wdata = wdata[1];
  assign rdata[0] = bus_a.mem_rdata;
  assign resp[0]  = bus_a.mem_resp;
  assign err[0]   = bus_a.addr_err;
  assign rdata[1] = bus_b.mem_rdata;
  assign resp[1]  = bus_b.mem_resp;
  assign err[1]   = bus_b.addr_err;
  assign hex[0]   = hex_a;
  assign hex[1]   = hex_b;

  slc3_mem_responder #(
    .ADDR_BITS(10), .WAIT_STATES(2), .IO_ADDR(16'hFFFF)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a),
    .switches(switches), .hex_out(hex_a)
  );

  slc3_mem_responder #(
    .ADDR_BITS(10), .WAIT_STATES(0), .IO_ADDR(16'hFFFF)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b),
    .switches(switches), .hex_out(hex_b)
  );

  // Reference model: what each memory should hold and report.
  word_t mref  [2][1024];
  bit    known [2][1024];
  word_t hex_m [2];
  word_t rd_m  [2];
  int    ws    [2];
  int    kq_a  [$];
  int    kq_b  [$];

  int checks = 0;
  int passed = 0;

  function automatic int region(input word_t a);
    if (a == 16'hFFFF) return 1;
    if (a < 16'd1024) return 0;
    return 2;
  endfunction

  task automatic model_apply(input int d, input logic w,
                             input word_t a, input word_t wd);
    int r;
    r = region(a);
    if (w) begin
      if (r == 0) begin
        mref[d][a[9:0]] = wd;
        if (!known[d][a[9:0]]) begin
          known[d][a[9:0]] = 1'b1;
          if (d == 0) kq_a.push_back(int'(a));
          else kq_b.push_back(int'(a));
        end
      end else if (r == 1) begin
        hex_m[d] = wd;
      end
    end else begin
      if (r == 0) rd_m[d] = mref[d][a[9:0]];
      else if (r == 1) rd_m[d] = switches;
      else rd_m[d] = 16'h0000;
    end
  endtask

  task automatic run_txn(input int d, input logic w, input word_t a,
                         input word_t wd, input bit perturb,
                         output int lat, output int bad,
                         output word_t rd, output logic e);
    lat = -1;
    bad = 0;
    rd  = '0;
    e   = 1'b0;
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    @(posedge clk); #1;
    if (perturb) begin
      addr[d]  = word_t'($urandom);
      wdata[d] = word_t'($urandom);
      we[d]    = ~w;
    end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (resp[d]) begin
        lat = i; rd = rdata[d]; e = err[d];
        break;
      end
      if (err[d]) bad++;
    end
    req[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rdata[d] !== 16'h0000)
        $display("FAIL reset_rdata[%0d] got %h want 0000", d, rdata[d]);
      else passed++;
      checks++;
      if (resp[d] !== 1'b0 || err[d] !== 1'b0)
        $display("FAIL reset_flags[%0d] got %b%b want 00", d, resp[d], err[d]);
      else passed++;
      checks++;
      if (hex[d] !== 16'h0000)
        $display("FAIL reset_hex[%0d] got %h want 0000", d, hex[d]);
      else passed++;
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ram_rw();
    int lat, bad; word_t rd; logic e;
    for (int d = 0; d < 2; d++) begin
      run_txn(d, 1'b1, 16'h0010, 16'h1234, 1'b0, lat, bad, rd, e);
      model_apply(d, 1'b1, 16'h0010, 16'h1234);
      checks++;
      if (lat !== ws[d] + 1 || e !== 1'b0 || bad !== 0)
        $display("FAIL ram_wr[%0d] got lat=%0d err=%b want lat=%0d err=0",
                 d, lat, e, ws[d] + 1);
      else passed++;
      run_txn(d, 1'b0, 16'h0010, 16'h0000, 1'b0, lat, bad, rd, e);
      model_apply(d, 1'b0, 16'h0010, 16'h0000);
      checks++;
      if (lat !== ws[d] + 1 || rd !== 16'h1234 || e !== 1'b0)
        $display("FAIL ram_rd[%0d] got lat=%0d rd=%h err=%b want lat=%0d rd=1234 err=0",
                 d, lat, rd, e, ws[d] + 1);
      else passed++;
    end
  endtask

  task automatic test_io();
    int lat, bad; word_t rd; logic e;
    run_txn(0, 1'b1, 16'h03FF, 16'h5555, 1'b0, lat, bad, rd, e);
    model_apply(0, 1'b1, 16'h03FF, 16'h5555);
    switches = 16'hA5A5;
    run_txn(0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, lat, bad, rd, e);
    model_apply(0, 1'b0, 16'hFFFF, 16'h0000);
    checks++;
    if (rd !== 16'hA5A5 || e !== 1'b0)
      $display("FAIL io_rd got rd=%h err=%b want rd=a5a5 err=0", rd, e);
    else passed++;
    run_txn(0, 1'b1, 16'hFFFF, 16'h00BE, 1'b0, lat, bad, rd, e);
    model_apply(0, 1'b1, 16'hFFFF, 16'h00BE);
    checks++;
    if (hex[0] !== 16'h00BE || rdata[0] !== 16'hA5A5)
      $display("FAIL io_wr got hex=%h rd=%h want hex=00be rd=a5a5",
               hex[0], rdata[0]);
    else passed++;
    run_txn(0, 1'b0, 16'h03FF, 16'h0000, 1'b0, lat, bad, rd, e);
    model_apply(0, 1'b0, 16'h03FF, 16'h0000);
    checks++;
    if (rd !== 16'h5555)
      $display("FAIL io_no_alias got %h want 5555", rd);
    else passed++;
  endtask

  task automatic test_addr_err();
    int lat, bad; word_t rd; logic e;
    run_txn(0, 1'b1, 16'h0000, 16'hC0DE, 1'b0, lat, bad, rd, e);
    model_apply(0, 1'b1, 16'h0000, 16'hC0DE);
    run_txn(0, 1'b0, 16'h0400, 16'h0000, 1'b0, lat, bad, rd, e);
    model_apply(0, 1'b0, 16'h0400, 16'h0000);
    checks++;
    if (lat !== 3 || rd !== 16'h0000 || e !== 1'b1 || bad !== 0)
      $display("FAIL err_rd got lat=%0d rd=%h err=%b early=%0d want lat=3 rd=0000 err=1 early=0",
               lat, rd, e, bad);
    else passed++;
    run_txn(0, 1'b1, 16'h0400, 16'hDEAD, 1'b0, lat, bad, rd, e);
    model_apply(0, 1'b1, 16'h0400, 16'hDEAD);
    checks++;
    if (e !== 1'b1 || rdata[0] !== 16'h0000)
      $display("FAIL err_wr got err=%b rd=%h want err=1 rd=0000", e, rdata[0]);
    else passed++;
    checks++;
    if (err[0] !== 1'b0)
      $display("FAIL err_pulse got %b want 0 after resp", err[0]);
    else passed++;
    run_txn(0, 1'b0, 16'h0000, 16'h0000, 1'b0, lat, bad, rd, e);
    model_apply(0, 1'b0, 16'h0000, 16'h0000);
    checks++;
    if (rd !== 16'hC0DE)
      $display("FAIL err_ram0 got %h want c0de", rd);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int lat, bad, n; word_t rd; logic e; word_t exp;
    int times [$];
    for (int k = 1; k <= 3; k++) begin
      run_txn(1, 1'b1, word_t'(k), word_t'(16'h0B00 + k), 1'b0, lat, bad, rd, e);
      model_apply(1, 1'b1, word_t'(k), word_t'(16'h0B00 + k));
    end
    n = 0;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0001;
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge clk);
      if (resp[1]) begin
        times.push_back(c);
        model_apply(1, 1'b0, word_t'(n + 1), 16'h0000);
        exp = rd_m[1];
        checks++;
        if (rdata[1] !== exp)
          $display("FAIL b2b_rd%0d got %h want %h", n, rdata[1], exp);
        else passed++;
        n++;
        addr[1] = word_t'(n + 1);
        if (n == 3) req[1] = 1'b0;
      end
    end
    req[1] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (times.size() != 3)
      $display("FAIL b2b_count got %0d want 3", times.size());
    else if (times[1] - times[0] != 2 || times[2] - times[1] != 2)
      $display("FAIL b2b_spacing got %0d,%0d want 2,2",
               times[1] - times[0], times[2] - times[1]);
    else passed++;
    // Bus changes while waiting must not leak into the result.
    run_txn(0, 1'b0, 16'h0010, 16'h0000, 1'b1, lat, bad, rd, e);
    model_apply(0, 1'b0, 16'h0010, 16'h0000);
    checks++;
    if (rd !== 16'h1234 || lat !== 3)
      $display("FAIL perturb_rd got rd=%h lat=%0d want rd=1234 lat=3", rd, lat);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int lat, bad; word_t rd; logic e;
    run_txn(0, 1'b1, 16'h0020, 16'h1111, 1'b0, lat, bad, rd, e);
    model_apply(0, 1'b1, 16'h0020, 16'h1111);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0020; wdata[0] = 16'h2222;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    req[0] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      hex_m[d] = 16'h0000;
      rd_m[d]  = 16'h0000;
    end
    checks++;
    if (rdata[0] !== 16'h0000 || resp[0] !== 1'b0 ||
        err[0] !== 1'b0 || hex[0] !== 16'h0000)
      $display("FAIL mid_reset got rd=%h resp=%b err=%b hex=%h want zeros",
               rdata[0], resp[0], err[0], hex[0]);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    run_txn(0, 1'b0, 16'h0020, 16'h0000, 1'b0, lat, bad, rd, e);
    model_apply(0, 1'b0, 16'h0020, 16'h0000);
    checks++;
    if (lat !== 3 || rd !== 16'h1111)
      $display("FAIL mid_reset_rd got lat=%0d rd=%h want lat=3 rd=1111", lat, rd);
    else passed++;
  endtask

  task automatic test_random();
    int lat, bad, d, sel, nk; word_t rd; logic e; logic w; word_t a, wd;
    for (int t = 0; t < 60; t++) begin
      d   = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      w   = 1'($urandom);
      wd  = word_t'($urandom);
      nk  = (d == 0) ? kq_a.size() : kq_b.size();
      if (sel < 6) begin
        if (w || nk == 0) begin
          w = 1'b1;
          a = word_t'($urandom_range(0, 1023));
        end else begin
          sel = int'($urandom_range(0, nk - 1));
          a = word_t'((d == 0) ? kq_a[sel] : kq_b[sel]);
        end
      end else if (sel < 8) begin
        a = 16'hFFFF;
      end else begin
        a = word_t'($urandom_range(16'h0400, 16'hFFFE));
      end
      switches = word_t'($urandom);
      run_txn(d, w, a, wd, 1'($urandom), lat, bad, rd, e);
      model_apply(d, w, a, wd);
      checks++;
      if (lat !== ws[d] + 1 || bad !== 0 ||
          e !== (region(a) == 2) || rd !== rd_m[d] || hex[d] !== hex_m[d])
        $display("FAIL rand%0d d=%0d we=%b a=%h got lat=%0d err=%b rd=%h hex=%h want lat=%0d err=%b rd=%h hex=%h",
                 t, d, w, a, lat, e, rd, hex[d],
                 ws[d] + 1, region(a) == 2, rd_m[d], hex_m[d]);
      else passed++;
    end
  endtask

  initial begin
    ws[0] = 2;
    ws[1] = 0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0;
      addr[d] = '0; wdata[d] = '0;
      hex_m[d] = '0; rd_m[d] = '0;
      for (int i = 0; i < 1024; i++) begin
        mref[d][i]  = '0;
        known[d][i] = 1'b0;
      end
    end
    switches = 16'h0000;
    reset = 1'b1;
    test_reset();
    test_ram_rw();
    test_io();
    test_addr_err();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
